// File: rtl/stack_operand_sequencer.sv
// ---------------------------------------------------------------------------
// stack_operand_sequencer
//
// Pops 0-3 operands from the shared operand stack on behalf of the execution
// unit. Each operand can be type-checked against the type the request expects.
// The operands are then offered as one bundle to a functional unit over a
// valid/ready handshake. If the request asks for it, the unit's result is
// accepted afterwards and pushed back onto the stack. This block is the only
// driver of the stack's op/data inputs. It raises a sticky trap for
// underflow, type mismatch and stack fault.
//
// Encodings (mirrors of the cpu.vh / stack.vh codes):
//   value type  (entry bits [WIDTH-1:WIDTH-2]): 0 i32, 1 i64, 2 f32, 3 f64
//   stack_op     : 0 NONE, 1 PUSH, 2 POP, 3 REPLACE (never generated here)
//   stack_status : 0 OK, 1 EMPTY, anything above EMPTY is a fault
//   err_code     : 0 none, 1 underflow, 2 type mismatch, 3 stack fault
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_nargs/type/check/push  request description (latched on accept)
//   opnd_valid/opnd_ready   operand bundle handshake
//   opnd_count, opnd0..2    bundle contents, opnd0 = deepest operand
//   res_valid/res_ready     result handshake, res_data = entry to push
//   stack_op/stack_data     registered command to the stack
//   stack_tos/stack_status  current stack top and status
//   busy, err, err_code     sequencer status and sticky trap
// ---------------------------------------------------------------------------
module stack_operand_sequencer #(
   parameter int WIDTH = 66
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_nargs,
   input  logic [1:0]       req_type,
   input  logic             req_check,
   input  logic             req_push,
   output logic             opnd_valid,
   input  logic             opnd_ready,
   output logic [1:0]       opnd_count,
   output logic [WIDTH-1:0] opnd0,
   output logic [WIDTH-1:0] opnd1,
   output logic [WIDTH-1:0] opnd2,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [WIDTH-1:0] res_data,
   output logic [1:0]       stack_op,
   output logic [WIDTH-1:0] stack_data,
   input  logic [WIDTH-1:0] stack_tos,
   input  logic [1:0]       stack_status,
   output logic             busy,
   output logic             err,
   output logic [1:0]       err_code
);

   localparam logic [1:0] OP_NONE       = 2'd0;
   localparam logic [1:0] OP_PUSH       = 2'd1;
   localparam logic [1:0] OP_POP        = 2'd2;
   localparam logic [1:0] STATUS_EMPTY  = 2'd1;
   localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
   localparam logic [1:0] ERR_TYPE      = 2'd2;
   localparam logic [1:0] ERR_FAULT     = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_SETTLE,
      S_ISSUE,
      S_WAIT_RES,
      S_PUSH_SETTLE,
      S_ERROR
   } state_t;

   state_t           state_q;
   logic [1:0]       rem_q;
   logic [1:0]       nargs_q;
   logic [1:0]       type_q;
   logic             check_q;
   logic             push_q;
   logic [WIDTH-1:0] opnd0_q;
   logic [WIDTH-1:0] opnd1_q;
   logic [WIDTH-1:0] opnd2_q;
   logic             opnd_valid_q;
   logic             res_ready_q;
   logic             req_ready_q;
   logic             busy_q;
   logic             err_q;
   logic [1:0]       err_code_q;
   logic [1:0]       stack_op_q;
   logic [WIDTH-1:0] stack_data_q;

   // Classification of the current stack top. It is used while capturing an
   // operand, and stackFault is also used after the result push.
   logic stackEmpty;
   logic stackFault;
   logic typeBad;

   assign stackEmpty = (stack_status == STATUS_EMPTY);
   assign stackFault = (stack_status > STATUS_EMPTY);
   assign typeBad    = check_q && (stack_tos[WIDTH-1 -: 2] != type_q);

   // Sequencer FSM. Every output is a register updated on the state
   // transition, so the outputs are glitch-free and line up with the state.
   // The stack sees a registered op, applies it at the following edge, and
   // shows the new top one cycle later. That is why a SETTLE cycle follows
   // every POP before the next capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rem_q        <= 2'd0;
         nargs_q      <= 2'd0;
         type_q       <= 2'd0;
         check_q      <= 1'b0;
         push_q       <= 1'b0;
         opnd0_q      <= '0;
         opnd1_q      <= '0;
         opnd2_q      <= '0;
         opnd_valid_q <= 1'b0;
         res_ready_q  <= 1'b0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= 2'd0;
         stack_op_q   <= OP_NONE;
         stack_data_q <= '0;
      end else begin
         stack_op_q <= OP_NONE;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  nargs_q <= req_nargs;
                  type_q  <= req_type;
                  check_q <= req_check;
                  push_q  <= req_push;
                  rem_q   <= req_nargs;
                  opnd0_q <= '0;
                  opnd1_q <= '0;
                  opnd2_q <= '0;
                  if (req_nargs != 2'd0) begin
                     state_q     <= S_CAPTURE;
                     req_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                  end else if (req_push) begin
                     state_q      <= S_ISSUE;
                     req_ready_q  <= 1'b0;
                     busy_q       <= 1'b1;
                     opnd_valid_q <= 1'b1;
                  end
               end
            end

            // Operands come off the stack TOS-first. Each one is stored in
            // slot rem-1, so opnd0 ends up holding the deepest operand.
            S_CAPTURE: begin
               if (stackEmpty) begin
                  state_q    <= S_ERROR;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_UNDERFLOW;
               end else if (stackFault) begin
                  state_q    <= S_ERROR;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_FAULT;
               end else if (typeBad) begin
                  state_q    <= S_ERROR;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_TYPE;
               end else begin
                  case (rem_q)
                     2'd1:    opnd0_q <= stack_tos;
                     2'd2:    opnd1_q <= stack_tos;
                     default: opnd2_q <= stack_tos;
                  endcase
                  stack_op_q <= OP_POP;
                  rem_q      <= rem_q - 2'd1;
                  state_q    <= S_SETTLE;
               end
            end

            S_SETTLE: begin
               if (rem_q != 2'd0) begin
                  state_q <= S_CAPTURE;
               end else begin
                  state_q      <= S_ISSUE;
                  opnd_valid_q <= 1'b1;
               end
            end

            S_ISSUE: begin
               if (opnd_ready) begin
                  opnd_valid_q <= 1'b0;
                  if (push_q) begin
                     state_q     <= S_WAIT_RES;
                     res_ready_q <= 1'b1;
                  end else begin
                     state_q     <= S_IDLE;
                     req_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end
               end
            end

            // The result is pushed exactly as delivered. Its type is the
            // functional unit's responsibility.
            S_WAIT_RES: begin
               if (res_valid) begin
                  res_ready_q  <= 1'b0;
                  stack_op_q   <= OP_PUSH;
                  stack_data_q <= res_data;
                  state_q      <= S_PUSH_SETTLE;
               end
            end

            S_PUSH_SETTLE: begin
               if (stackFault) begin
                  state_q    <= S_ERROR;
                  err_q      <= 1'b1;
                  err_code_q <= ERR_FAULT;
               end else begin
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end

            // The trap is terminal. Only reset clears it, and every
            // handshake stays closed until then.
            S_ERROR: begin
               req_ready_q  <= 1'b0;
               opnd_valid_q <= 1'b0;
               res_ready_q  <= 1'b0;
            end

            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign opnd_valid = opnd_valid_q;
   assign opnd_count = nargs_q;
   assign opnd0      = opnd0_q;
   assign opnd1      = opnd1_q;
   assign opnd2      = opnd2_q;
   assign res_ready  = res_ready_q;
   assign stack_op   = stack_op_q;
   assign stack_data = stack_data_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_stack_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_operand_sequencer
//
// Directed bench for stack_operand_sequencer. It contains a small
// behavioural operand stack (depth 4). The stack reports FULL as a fault
// status, and it latches an overflow/underflow error code. The bench can
// preload the stack directly. Expected operand bundles go into a queue when
// a request is driven. They are popped and compared when the sequencer
// presents the bundle.
// ---------------------------------------------------------------------------
module tb_stack_operand_sequencer;

   localparam int WIDTH = 66;
   localparam int DEPTH = 4;

   localparam logic [1:0] OP_NONE  = 2'd0;
   localparam logic [1:0] OP_PUSH  = 2'd1;
   localparam logic [1:0] OP_POP   = 2'd2;
   localparam logic [1:0] ST_OK    = 2'd0;
   localparam logic [1:0] ST_EMPTY = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;
   localparam logic [1:0] T_I32    = 2'd0;
   localparam logic [1:0] T_I64    = 2'd1;
   localparam logic [1:0] T_F32    = 2'd2;

   typedef struct {
      logic [1:0]       cnt;
      logic [WIDTH-1:0] o0;
      logic [WIDTH-1:0] o1;
      logic [WIDTH-1:0] o2;
   } bundle_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_nargs;
   logic [1:0]       req_type;
   logic             req_check;
   logic             req_push;
   logic             opnd_valid;
   logic             opnd_ready;
   logic [1:0]       opnd_count;
   logic [WIDTH-1:0] opnd0;
   logic [WIDTH-1:0] opnd1;
   logic [WIDTH-1:0] opnd2;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [1:0]       stack_op;
   logic [WIDTH-1:0] stack_data;
   logic [WIDTH-1:0] stack_tos;
   logic [1:0]       stack_status;
   logic             busy;
   logic             err;
   logic [1:0]       err_code;

   // Stack model state and preload path
   logic [WIDTH-1:0] stkMem [DEPTH];
   logic [2:0]       stkCount;
   logic             stkOvf;
   logic             tbLoad;
   logic [2:0]       tbLoadCount;
   logic [WIDTH-1:0] tbLoadMem [DEPTH];

   int popCount  = 0;
   int pushCount = 0;
   int compareCount  = 0;
   int mismatchCount = 0;
   bundle_t expQ[$];

   always #5 clk = ~clk;

   stack_operand_sequencer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_nargs   (req_nargs),
      .req_type    (req_type),
      .req_check   (req_check),
      .req_push    (req_push),
      .opnd_valid  (opnd_valid),
      .opnd_ready  (opnd_ready),
      .opnd_count  (opnd_count),
      .opnd0       (opnd0),
      .opnd1       (opnd1),
      .opnd2       (opnd2),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .stack_op    (stack_op),
      .stack_data  (stack_data),
      .stack_tos   (stack_tos),
      .stack_status(stack_status),
      .busy        (busy),
      .err         (err),
      .err_code    (err_code)
   );

   // Behavioural stack: applies the registered op at the next edge
   always @(posedge clk) begin
      if (reset) begin
         stkCount <= 3'd0;
         stkOvf   <= 1'b0;
      end else if (tbLoad) begin
         stkCount <= tbLoadCount;
         stkOvf   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stkMem[i] <= tbLoadMem[i];
      end else begin
         case (stack_op)
            OP_PUSH: begin
               if (stkCount == 3'(DEPTH)) stkOvf <= 1'b1;
               else begin
                  stkMem[stkCount[1:0]] <= stack_data;
                  stkCount <= stkCount + 3'd1;
               end
            end
            OP_POP: begin
               if (stkCount == 3'd0) stkOvf <= 1'b1;
               else stkCount <= stkCount - 3'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stack_tos = '0;
      if (stkCount != 3'd0) stack_tos = stkMem[2'(stkCount - 3'd1)];
      if (stkOvf) stack_status = ST_ERR;
      else if (stkCount == 3'd0) stack_status = ST_EMPTY;
      else if (stkCount == 3'(DEPTH)) stack_status = ST_FULL;
      else stack_status = ST_OK;
   end

   // Counts of stack commands issued by the sequencer
   always @(posedge clk) begin
      if (!reset) begin
         if (stack_op == OP_POP)  popCount  <= popCount + 1;
         if (stack_op == OP_PUSH) pushCount <= pushCount + 1;
      end
   end

   function automatic logic [WIDTH-1:0] mk(input logic [1:0] t, input logic [63:0] v);
      return {t, v};
   endfunction

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         mismatchCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic resetDut();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic preloadStack(input logic [2:0] cnt, input logic [WIDTH-1:0] m0,
                               input logic [WIDTH-1:0] m1, input logic [WIDTH-1:0] m2,
                               input logic [WIDTH-1:0] m3);
      tbLoad       = 1'b1;
      tbLoadCount  = cnt;
      tbLoadMem[0] = m0;
      tbLoadMem[1] = m1;
      tbLoadMem[2] = m2;
      tbLoadMem[3] = m3;
      @(negedge clk);
      tbLoad = 1'b0;
   endtask

   // Drives one request for one cycle and records the expected bundle
   task automatic applyStimulus(input logic [1:0] nargs, input logic [1:0] rtype,
                                input logic chk, input logic push, input logic expectBundle,
                                input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                                input logic [WIDTH-1:0] e2);
      bundle_t b;
      req_valid = 1'b1;
      req_nargs = nargs;
      req_type  = rtype;
      req_check = chk;
      req_push  = push;
      if (expectBundle) begin
         b.cnt = nargs;
         b.o0  = e0;
         b.o1  = e1;
         b.o2  = e2;
         expQ.push_back(b);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic checkBundle(input string tag);
      bundle_t b;
      checkOutput({tag, "_sb_nonempty"}, (expQ.size() != 0), 1'b1);
      if (expQ.size() != 0) begin
         b = expQ.pop_front();
         checkOutput({tag, "_count"}, opnd_count, b.cnt);
         checkOutput({tag, "_opnd0"}, opnd0, b.o0);
         checkOutput({tag, "_opnd1"}, opnd1, b.o1);
         checkOutput({tag, "_opnd2"}, opnd2, b.o2);
      end
   endtask

   // Starts in cycle 1 (the cycle after accept) and returns the cycle index
   task automatic waitBundle(input string tag, input int budget, output int cyc);
      cyc = 1;
      while (opnd_valid !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, "_valid_seen"}, opnd_valid, 1'b1);
      if (opnd_valid === 1'b1) checkBundle(tag);
   endtask

   task automatic waitErr(input string tag, input int budget, output int cyc);
      cyc = 1;
      while (err !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, "_err_seen"}, err, 1'b1);
   endtask

   initial begin
      int cyc;
      int pops0;
      int pushes0;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_nargs   = 2'd0;
      req_type    = 2'd0;
      req_check   = 1'b0;
      req_push    = 1'b0;
      opnd_ready  = 1'b0;
      res_valid   = 1'b0;
      res_data    = '0;
      tbLoad      = 1'b0;
      tbLoadCount = 3'd0;
      for (int i = 0; i < DEPTH; i++) tbLoadMem[i] = '0;

      $display("[TB] reset values");
      resetDut();
      checkOutput("rst_req_ready", req_ready, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_opnd_valid", opnd_valid, 1'b0);
      checkOutput("rst_res_ready", res_ready, 1'b0);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_err_code", err_code, 2'd0);
      checkOutput("rst_stack_op", stack_op, OP_NONE);
      checkOutput("rst_stack_data", stack_data, '0);
      checkOutput("rst_opnd0", opnd0, '0);

      $display("[TB] add: [i32 5, i32 7] -> push i32 12");
      preloadStack(3'd2, mk(T_I32, 64'd5), mk(T_I32, 64'd7), '0, '0);
      pops0 = popCount;
      pushes0 = pushCount;
      opnd_ready = 1'b1;
      applyStimulus(2'd2, T_I32, 1'b1, 1'b1, 1'b1, mk(T_I32, 64'd5), mk(T_I32, 64'd7), '0);
      waitBundle("add", 20, cyc);
      checkOutput("add_latency", 66'(cyc), 66'd5);
      @(negedge clk);
      checkOutput("add_res_ready", res_ready, 1'b1);
      res_valid = 1'b1;
      res_data  = mk(T_I32, 64'd12);
      @(negedge clk);
      res_valid = 1'b0;
      checkOutput("add_push_op", stack_op, OP_PUSH);
      checkOutput("add_push_data", stack_data, mk(T_I32, 64'd12));
      checkOutput("add_res_ready_drop", res_ready, 1'b0);
      @(negedge clk);
      checkOutput("add_idle", busy, 1'b0);
      checkOutput("add_req_ready", req_ready, 1'b1);
      checkOutput("add_pops", 66'(popCount - pops0), 66'd2);
      checkOutput("add_pushes", 66'(pushCount - pushes0), 66'd1);
      checkOutput("add_stack_count", stkCount, 3'd1);
      checkOutput("add_stack_top", stack_tos, mk(T_I32, 64'd12));
      checkOutput("add_err", err, 1'b0);

      $display("[TB] type mismatch: [i32 1, i64 9] expecting i32");
      resetDut();
      preloadStack(3'd2, mk(T_I32, 64'd1), mk(T_I64, 64'd9), '0, '0);
      pops0 = popCount;
      applyStimulus(2'd2, T_I32, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      waitErr("type", 10, cyc);
      checkOutput("type_latency", 66'(cyc), 66'd2);
      checkOutput("type_code", err_code, 2'd2);
      for (int i = 0; i < 3; i++) begin
         checkOutput("type_req_ready_low", req_ready, 1'b0);
         checkOutput("type_opnd_valid_low", opnd_valid, 1'b0);
         @(negedge clk);
      end
      checkOutput("type_no_pop", 66'(popCount - pops0), 66'd0);
      checkOutput("type_stack_count", stkCount, 3'd2);
      checkOutput("type_stack_top", stack_tos, mk(T_I64, 64'd9));

      $display("[TB] underflow on empty stack");
      resetDut();
      pops0 = popCount;
      pushes0 = pushCount;
      applyStimulus(2'd1, T_I32, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      waitErr("uflow", 10, cyc);
      checkOutput("uflow_code", err_code, 2'd1);
      checkOutput("uflow_no_ops", 66'((popCount - pops0) + (pushCount - pushes0)), 66'd0);

      $display("[TB] f32 operand with stalled consumer");
      resetDut();
      preloadStack(3'd1, mk(T_F32, 64'h3F80_0000), '0, '0, '0);
      opnd_ready = 1'b0;
      applyStimulus(2'd1, T_I64, 1'b0, 1'b0, 1'b1, mk(T_F32, 64'h3F80_0000), '0, '0);
      waitBundle("stall", 20, cyc);
      checkOutput("stall_latency", 66'(cyc), 66'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_valid_held", opnd_valid, 1'b1);
         checkOutput("stall_opnd0_held", opnd0, mk(T_F32, 64'h3F80_0000));
      end
      opnd_ready = 1'b1;
      @(negedge clk);
      checkOutput("stall_idle", busy, 1'b0);
      checkOutput("stall_req_ready", req_ready, 1'b1);
      checkOutput("stall_opnd_valid_drop", opnd_valid, 1'b0);
      checkOutput("stall_stack_empty", stkCount, 3'd0);

      $display("[TB] nargs=0 push of i64 0xDEAD");
      resetDut();
      preloadStack(3'd1, mk(T_I32, 64'd3), '0, '0, '0);
      pushes0 = pushCount;
      opnd_ready = 1'b1;
      applyStimulus(2'd0, T_I32, 1'b0, 1'b1, 1'b1, '0, '0, '0);
      waitBundle("const", 10, cyc);
      checkOutput("const_latency", 66'(cyc), 66'd1);
      @(negedge clk);
      checkOutput("const_res_ready", res_ready, 1'b1);
      res_valid = 1'b1;
      res_data  = mk(T_I64, 64'hDEAD);
      @(negedge clk);
      res_valid = 1'b0;
      checkOutput("const_push_data", stack_data, mk(T_I64, 64'hDEAD));
      @(negedge clk);
      checkOutput("const_idle", busy, 1'b0);
      checkOutput("const_pushes", 66'(pushCount - pushes0), 66'd1);
      checkOutput("const_stack_top", stack_tos, mk(T_I64, 64'hDEAD));
      checkOutput("const_err", err, 1'b0);

      $display("[TB] nargs=0 push onto full stack");
      preloadStack(3'd4, mk(T_I32, 64'd1), mk(T_I32, 64'd2), mk(T_I32, 64'd3), mk(T_I32, 64'd4));
      applyStimulus(2'd0, T_I32, 1'b0, 1'b1, 1'b1, '0, '0, '0);
      waitBundle("full", 10, cyc);
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = mk(T_I64, 64'hDEAD);
      @(negedge clk);
      res_valid = 1'b0;
      waitErr("full", 10, cyc);
      checkOutput("full_code", err_code, 2'd3);
      checkOutput("full_req_ready", req_ready, 1'b0);

      $display("[TB] reset during WAIT_RES");
      resetDut();
      preloadStack(3'd2, mk(T_I32, 64'd3), mk(T_I32, 64'd4), '0, '0);
      opnd_ready = 1'b1;
      applyStimulus(2'd2, T_I32, 1'b1, 1'b1, 1'b1, mk(T_I32, 64'd3), mk(T_I32, 64'd4), '0);
      waitBundle("midrst", 20, cyc);
      @(negedge clk);
      checkOutput("midrst_in_wait", res_ready, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_req_ready", req_ready, 1'b1);
      checkOutput("midrst_res_ready", res_ready, 1'b0);
      checkOutput("midrst_err", err, 1'b0);
      reset = 1'b0;
      preloadStack(3'd1, mk(T_I32, 64'd2), '0, '0, '0);
      applyStimulus(2'd1, T_I32, 1'b1, 1'b0, 1'b1, mk(T_I32, 64'd2), '0, '0);
      waitBundle("after", 20, cyc);
      checkOutput("after_latency", 66'(cyc), 66'd3);
      @(negedge clk);
      checkOutput("after_idle", busy, 1'b0);
      checkOutput("after_stack_empty", stkCount, 3'd0);
      checkOutput("after_err", err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
